shot_arbiter: RTL and testbench

SHOT_ARBITER -- requirements
Module: shot_arbiter

---
 rtl/shot_arb_pkg.sv | 32 +++
 rtl/score_ctr.sv | 47 ++++
 rtl/shot_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_shot_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : shot_arb_pkg                                               |
// | Purpose : Shared definitions for shot_arbiter: FSM state encoding,   |
// |           bit offsets of the packed shot word and default game       |
// |           constants.                                                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package shot_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_REPORT = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Shot word layout: {dir[15], run[14:10], rise[9:5], x[4:0]}
  localparam int c_X_LSB    = 0;
  localparam int c_RISE_LSB = 5;
  localparam int c_RUN_LSB  = 10;
  localparam int c_DIR_BIT  = 15;
  localparam int c_FIELD_W  = 5;

  localparam int c_WIN_SCORE_DEF = 7;
  localparam int c_TIMEOUT_DEF   = 40;

  localparam logic [3:0] c_SCORE_MAX = 4'd15;

endpackage
`default_nettype wire

// File: rtl/score_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : score_ctr                                                  |
// | Purpose : 4-bit saturating score counter with synchronous clear and  |
// |           increment. Also exposes the value it will take on the next |
// |           edge so the owner can make decisions on the updated score. |
// | Ports   : clk, rst (async active-low), i_clr, i_inc,                 |
// |           o_q (current score), o_q_next (score after this edge)      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module score_ctr
  import shot_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_q,
  output logic [3:0] o_q_next
);

  logic [3:0] r_q;
  logic [3:0] w_q_next;

  // Clear dominates increment; increment stops at the maximum.
  always_comb begin
    w_q_next = r_q;
    if (i_clr) begin
      w_q_next = '0;
    end else if (i_inc && (r_q != c_SCORE_MAX)) begin
      w_q_next = r_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign o_q      = r_q;
  assign o_q_next = w_q_next;

endmodule
`default_nettype wire

// File: rtl/shot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shot_arbiter                                               |
// | Purpose : Two-player shot arbiter. Grants one shot request at a time |
// |           (round-robin), hands the latched shot to an external       |
// |           trajectory datapath, waits for its result or a timeout,    |
// |           reports back to the shooter and keeps score.               |
// | Ports   : clk, rst (async active-low)                                |
// |           req[1:0], p0_shot/p1_shot[15:0], new_game      - players   |
// |           gnt[1:0], done[1:0], hit_out, timeout          - to player |
// |           calc_shoot, calc_x/rise/run, calc_dir          - datapath  |
// |           calc_valid, calc_hit                           - datapath  |
// |           score0/score1[3:0], game_over, winner[1:0]     - status    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module shot_arbiter
  import shot_arb_pkg::*;
#(
  parameter int WIN_SCORE = c_WIN_SCORE_DEF,
  parameter int TIMEOUT   = c_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] p0_shot,
  input  logic [15:0] p1_shot,
  input  logic        new_game,
  output logic [1:0]  gnt,
  output logic        calc_shoot,
  output logic [4:0]  calc_x,
  output logic [4:0]  calc_rise,
  output logic [4:0]  calc_run,
  output logic        calc_dir,
  input  logic        calc_valid,
  input  logic        calc_hit,
  output logic [1:0]  done,
  output logic        hit_out,
  output logic        timeout,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [3:0] c_WIN      = 4'(WIN_SCORE);
  localparam logic [5:0] c_TMO_LAST = 6'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_owner;     // player holding the current grant
  logic        r_prio;      // player that wins a simultaneous request
  logic [15:0] r_shot;
  logic [5:0]  r_cnt;
  logic        r_hit;
  logic        r_tmo;

  logic        w_gnt_p;
  logic        w_take;
  logic        w_clr;
  logic        w_inc0;
  logic        w_inc1;
  logic        w_expired;
  logic [3:0]  w_s0_next;
  logic [3:0]  w_s1_next;
  logic [3:0]  w_owner_next;

  // A lone requester always wins; a tie goes to the priority holder.
  assign w_gnt_p      = (req == 2'b11) ? r_prio : req[1];
  assign w_expired    = (r_cnt == c_TMO_LAST);
  assign w_owner_next = r_owner ? w_s1_next : w_s0_next;

  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_clr        = 1'b0;
    w_inc0       = 1'b0;
    w_inc1       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // new_game takes the cycle: clear and do not grant.
        if (new_game) begin
          w_clr = 1'b1;
        end else if (req != 2'b00) begin
          w_take       = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (calc_valid || w_expired) begin
          w_next_state = ST_REPORT;
        end
      end
      ST_REPORT: begin
        w_inc0 = r_hit & ~r_owner;
        w_inc1 = r_hit & r_owner;
        // Decide on the score as it will stand after this increment.
        w_next_state = (w_owner_next >= c_WIN) ? ST_OVER : ST_IDLE;
      end
      ST_OVER: begin
        if (new_game) begin
          w_clr        = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_shot  <= '0;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_clr) begin
        r_prio <= 1'b0;
      end
      if (w_take) begin
        r_owner <= w_gnt_p;
        r_prio  <= ~w_gnt_p;
        r_shot  <= w_gnt_p ? p1_shot : p0_shot;
      end
      // Counter cleared in ISSUE so the first WAIT cycle sees zero.
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
        r_hit <= 1'b0;
        r_tmo <= 1'b0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 6'd1;
        // A result arriving on the expiry cycle beats the timeout.
        if (calc_valid) begin
          r_hit <= calc_hit;
          r_tmo <= 1'b0;
        end else if (w_expired) begin
          r_hit <= 1'b0;
          r_tmo <= 1'b1;
        end
      end
    end
  end

  score_ctr u_score0 (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_inc    (w_inc0),
    .o_q      (score0),
    .o_q_next (w_s0_next)
  );

  score_ctr u_score1 (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_inc    (w_inc1),
    .o_q      (score1),
    .o_q_next (w_s1_next)
  );

  // All outputs decode registered state, so reset forces them low at once.
  assign gnt        = (r_state == ST_ISSUE)  ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign calc_shoot = (r_state == ST_ISSUE);
  assign done       = (r_state == ST_REPORT) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign hit_out    = (r_state == ST_REPORT) & r_hit;
  assign timeout    = (r_state == ST_REPORT) & r_tmo;
  assign game_over  = (r_state == ST_OVER);
  assign winner     = (r_state == ST_OVER) ? {(score1 >= c_WIN), (score0 >= c_WIN)} : 2'b00;

  assign calc_x    = r_shot[c_X_LSB    +: c_FIELD_W];
  assign calc_rise = r_shot[c_RISE_LSB +: c_FIELD_W];
  assign calc_run  = r_shot[c_RUN_LSB  +: c_FIELD_W];
  assign calc_dir  = r_shot[c_DIR_BIT];

endmodule
`default_nettype wire

// File: tb/tb_shot_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_shot_arbiter                                            |
// | Purpose : Self-checking bench for shot_arbiter with a game-level     |
// |           reference model (scores, round-robin priority, result).    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_shot_arbiter;

  localparam int WIN = 7;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] p0_shot = '0;
  logic [15:0] p1_shot = '0;
  logic        new_game = 1'b0;
  logic        calc_valid = 1'b0;
  logic        calc_hit = 1'b0;
  logic [1:0]  gnt;
  logic        calc_shoot;
  logic [4:0]  calc_x;
  logic [4:0]  calc_rise;
  logic [4:0]  calc_run;
  logic        calc_dir;
  logic [1:0]  done;
  logic        hit_out;
  logic        timeout;
  logic [3:0]  score0;
  logic [3:0]  score1;
  logic        game_over;
  logic [1:0]  winner;

  int checks   = 0;
  int failures = 0;

  // Reference model: game state as a player would describe it.
  int m_score[2];
  int m_prio;      // who wins a tie
  bit m_over;

  shot_arbiter #(.WIN_SCORE(WIN), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .p0_shot    (p0_shot),
    .p1_shot    (p1_shot),
    .new_game   (new_game),
    .gnt        (gnt),
    .calc_shoot (calc_shoot),
    .calc_x     (calc_x),
    .calc_rise  (calc_rise),
    .calc_run   (calc_run),
    .calc_dir   (calc_dir),
    .calc_valid (calc_valid),
    .calc_hit   (calc_hit),
    .done       (done),
    .hit_out    (hit_out),
    .timeout    (timeout),
    .score0     (score0),
    .score1     (score1),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh(input int p);
    return (p != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_score[0] = 0;
    m_score[1] = 0;
    m_prio     = 0;
    m_over     = 1'b0;
  endtask

  // One complete shot starting from an IDLE cycle. d = WAIT cycle index
  // (0-based) carrying calc_valid; d < 0 means the datapath never answers.
  // noise drives calc_valid/new_game where they must be ignored.
  task automatic do_shot(input logic [1:0] rq, input logic [15:0] s0, input logic [15:0] s1,
                         input int d, input bit hv, input bit noise);
    int          g;
    int          e;
    bit          exp_tmo;
    bit          exp_hit;
    bit          early;
    logic [15:0] sh;
    logic [1:0]  exp_win;
    req     = rq;
    p0_shot = s0;
    p1_shot = s1;
    g       = (rq == 2'b11) ? m_prio : (rq[1] ? 1 : 0);
    sh      = (g != 0) ? s1 : s0;
    m_prio  = 1 - g;
    exp_tmo = (d < 0) || (d > TMO - 1);
    e       = exp_tmo ? TMO - 1 : d;
    exp_hit = exp_tmo ? 1'b0 : hv;
    step();  // ISSUE
    checks++;
    if (gnt !== oh(g) || calc_shoot !== 1'b1) begin
      failures++;
      $display("FAIL grant: gnt=%b shoot=%b expected gnt=%b shoot=1", gnt, calc_shoot, oh(g));
    end
    checks++;
    if ({calc_dir, calc_run, calc_rise, calc_x} !== sh) begin
      failures++;
      $display("FAIL calc_fields_issue: got %h expected %h", {calc_dir, calc_run, calc_rise, calc_x}, sh);
    end
    p0_shot = 16'($urandom);
    p1_shot = 16'($urandom);
    if (noise) begin
      calc_valid = 1'b1;
      calc_hit   = 1'b1;
      new_game   = 1'b1;
    end
    early = 1'b0;
    for (int i = 0; i <= e; i++) begin
      step();  // WAIT cycle i
      if (done !== 2'b00 || gnt !== 2'b00 || calc_shoot !== 1'b0) early = 1'b1;
      calc_valid = (i == d);
      calc_hit   = hv;
      new_game   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    step();  // REPORT
    calc_valid = noise;
    new_game   = noise;
    checks++;
    if (early) begin
      failures++;
      $display("FAIL wait_quiet: done/gnt/shoot active during WAIT, expected all 0");
    end
    checks++;
    if (done !== oh(g) || hit_out !== exp_hit || timeout !== exp_tmo) begin
      failures++;
      $display("FAIL report: done=%b hit=%b tmo=%b expected done=%b hit=%b tmo=%b",
               done, hit_out, timeout, oh(g), exp_hit, exp_tmo);
    end
    checks++;
    if ({calc_dir, calc_run, calc_rise, calc_x} !== sh) begin
      failures++;
      $display("FAIL calc_fields_report: got %h expected %h", {calc_dir, calc_run, calc_rise, calc_x}, sh);
    end
    if (exp_hit && m_score[g] < 15) m_score[g]++;
    m_over  = (m_score[g] >= WIN);
    exp_win = m_over ? oh(g) : 2'b00;
    step();  // IDLE or OVER
    calc_valid = 1'b0;
    calc_hit   = 1'b0;
    new_game   = 1'b0;
    req        = 2'b00;
    checks++;
    if (score0 !== 4'(m_score[0]) || score1 !== 4'(m_score[1])) begin
      failures++;
      $display("FAIL scores: got %0d/%0d expected %0d/%0d", score0, score1, m_score[0], m_score[1]);
    end
    checks++;
    if (game_over !== m_over || winner !== exp_win || done !== 2'b00) begin
      failures++;
      $display("FAIL after_report: over=%b winner=%b done=%b expected over=%b winner=%b done=00",
               game_over, winner, done, m_over, exp_win);
    end
  endtask

  // In OVER: requests must be ignored until new_game restarts the game.
  task automatic over_and_restart();
    logic [1:0] exp_win;
    exp_win = (m_score[1] >= WIN) ? 2'b10 : 2'b01;
    for (int i = 0; i < 3; i++) begin
      req = 2'($urandom_range(1, 3));
      step();
      checks++;
      if (gnt !== 2'b00 || calc_shoot !== 1'b0 || game_over !== 1'b1 || winner !== exp_win) begin
        failures++;
        $display("FAIL over_hold: gnt=%b shoot=%b over=%b winner=%b expected 00/0/1/%b",
                 gnt, calc_shoot, game_over, winner, exp_win);
      end
    end
    req      = 2'b11;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    req      = 2'b00;
    model_clear();
    checks++;
    if (score0 !== 4'd0 || score1 !== 4'd0 || game_over !== 1'b0 || winner !== 2'b00 || gnt !== 2'b00) begin
      failures++;
      $display("FAIL over_restart: s0=%0d s1=%0d over=%b winner=%b gnt=%b expected 0/0/0/00/00",
               score0, score1, game_over, winner, gnt);
    end
  endtask

  task automatic new_game_idle();
    req      = 2'b11;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    req      = 2'b00;
    model_clear();
    checks++;
    if (gnt !== 2'b00 || calc_shoot !== 1'b0 || score0 !== 4'd0 || score1 !== 4'd0) begin
      failures++;
      $display("FAIL new_game_idle: gnt=%b shoot=%b s0=%0d s1=%0d expected 00/0/0/0",
               gnt, calc_shoot, score0, score1);
    end
  endtask

  task automatic test_reset();
    req = 2'b11;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gnt, done, calc_shoot, hit_out, timeout, game_over, winner, score0, score1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {gnt, done, calc_shoot, hit_out, timeout, game_over, winner, score0, score1});
    end
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_shot(2'b01, {1'b1, 5'd2, 5'd3, 5'd4}, 16'h0000, 2, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    new_game_idle();
    for (int i = 0; i < 4; i++)
      do_shot(2'b11, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_shot(2'b10, 16'($urandom), 16'($urandom), -1, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    do_shot(2'b01, 16'($urandom), 16'($urandom), TMO - 1, 1'b1, 1'b0);
  endtask

  task automatic test_new_game_clear();
    do_shot(2'b01, 16'($urandom), 16'($urandom), 0, 1'b1, 1'b1);
    new_game_idle();
    do_shot(2'b11, 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
  endtask

  task automatic test_win();
    new_game_idle();
    for (int i = 0; i < WIN; i++)
      do_shot(2'b10, 16'($urandom), 16'($urandom), 0, 1'b1, 1'b0);
    checks++;
    if (!m_over || winner !== 2'b10) begin
      failures++;
      $display("FAIL win_p1: over=%b winner=%b expected over=1 winner=10", game_over, winner);
    end
    over_and_restart();
  endtask

  task automatic test_reset_mid_wait();
    bit seen_done;
    do_shot(2'b01, 16'($urandom), 16'($urandom), 0, 1'b1, 1'b0);
    req = 2'b01;
    step();  // ISSUE
    req = 2'b00;
    step();  // WAIT 0
    step();  // WAIT 1
    #2 rst = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({gnt, done, calc_shoot, hit_out, timeout, game_over, winner, score0, score1,
         calc_dir, calc_run, calc_rise, calc_x} !== '0) begin
      failures++;
      $display("FAIL reset_async: got %b expected all zero",
               {gnt, done, calc_shoot, hit_out, timeout, game_over, winner, score0, score1,
                calc_dir, calc_run, calc_rise, calc_x});
    end
    calc_valid = 1'b1;
    calc_hit   = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done !== 2'b00 || gnt !== 2'b00) seen_done = 1'b1;
    end
    calc_valid = 1'b0;
    calc_hit   = 1'b0;
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL reset_no_done: done/gnt pulsed after reset, expected none");
    end
    do_shot(2'b11, 16'($urandom), 16'($urandom), 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int r;
    int d;
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       d = int'($urandom_range(0, 6));
      else if (r == 7) d = -1;
      else if (r == 8) d = TMO - 1;
      else             d = TMO - 2;
      do_shot(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), d,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (m_over) over_and_restart();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_new_game_clear();
    test_win();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
